// File: rtl/d_cache_pkg.sv
// Shared constants and state encoding for the d_cache slice.
package d_cache_pkg;
  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: asynchronous lookup, synchronous line fill and word update.
module cache_array #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8,
  parameter int INDEX_W    = 3,
  parameter int OFFSET_W   = 2,
  parameter int TAG_W      = 11
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [INDEX_W-1:0]              rd_index,
  output logic                            rd_valid,
  output logic [TAG_W-1:0]                rd_tag,
  output logic [LINE_WORDS*WORD_SIZE-1:0] rd_line,
  input  logic [INDEX_W-1:0]              wr_index,
  input  logic                            line_we,
  input  logic [TAG_W-1:0]                line_tag,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] line_data,
  input  logic                            word_we,
  input  logic [OFFSET_W-1:0]             word_offset,
  input  logic [WORD_SIZE-1:0]            word_data
);
  logic [NUM_LINES-1:0]            valid_q, valid_d;
  logic [TAG_W-1:0]                tag_mem  [NUM_LINES];
  logic [LINE_WORDS*WORD_SIZE-1:0] data_mem [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

  always_comb begin
    valid_d = valid_q;
    if (line_we) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[wr_index]  <= line_tag;
      data_mem[wr_index] <= line_data;
    end else if (word_we) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        if (word_offset == OFFSET_W'(i))
          data_mem[wr_index][i*WORD_SIZE +: WORD_SIZE] <= word_data;
      end
    end
  end
endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with hit/miss statistics.
module d_cache
  import d_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [WORD_SIZE-1:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            cpu_ready,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
  input  logic                            mem_ready,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);
  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = WORD_SIZE - OFFSET_W - INDEX_W;

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                 hit_q, hit_d, fill_done_q, fill_done_d, refill_done_q, refill_done_d;
  logic [15:0]          hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  logic [INDEX_W-1:0]              cpu_index, lat_index;
  logic [OFFSET_W-1:0]             cpu_offset, lat_offset;
  logic [TAG_W-1:0]                cpu_tag, lat_tag, rd_tag;
  logic                            rd_valid, lookup_hit, line_we, word_we;
  logic [LINE_WORDS*WORD_SIZE-1:0] rd_line;
  logic [WORD_SIZE-1:0]            rd_word;

  assign cpu_offset = cpu_addr[OFFSET_W-1:0];
  assign cpu_index  = cpu_addr[OFFSET_W +: INDEX_W];
  assign cpu_tag    = cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign lat_offset = mem_addr_q[OFFSET_W-1:0];
  assign lat_index  = mem_addr_q[OFFSET_W +: INDEX_W];
  assign lat_tag    = mem_addr_q[WORD_SIZE-1 -: TAG_W];
  assign lookup_hit = rd_valid && (rd_tag == cpu_tag);

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  cache_array #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .OFFSET_W  (OFFSET_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_index   (cpu_index),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .wr_index   (lat_index),
    .line_we    (line_we),
    .line_tag   (lat_tag),
    .line_data  (mem_rdata),
    .word_we    (word_we),
    .word_offset(lat_offset),
    .word_data  (mem_wdata_q)
  );

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      if (cpu_offset == OFFSET_W'(i)) rd_word = rd_line[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    hit_d         = hit_q;
    fill_done_d   = fill_done_q;
    refill_done_d = refill_done_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    cpu_ready     = 1'b0;
    cpu_rdata     = '0;
    line_we       = 1'b0;
    word_we       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_write) begin
          state_d     = ST_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          hit_d       = lookup_hit;
          if (lookup_hit) hit_count_d  = hit_count_q + 16'd1;
          else            miss_count_d = miss_count_q + 16'd1;
        end else if (cpu_read) begin
          if (lookup_hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = rd_word;
            // The load that caused a refill completes here; it was already counted as a miss.
            if (refill_done_q) refill_done_d = 1'b0;
            else               hit_count_d   = hit_count_q + 16'd1;
          end else begin
            state_d      = ST_FILL;
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = {cpu_addr[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
            fill_done_d  = 1'b0;
            miss_count_d = miss_count_q + 16'd1;
          end
        end else begin
          cpu_ready = 1'b1;
        end
      end
      ST_FILL: begin
        // The line is written on the mem_ready edge; FILL lingers one more cycle before the load retries.
        if (fill_done_q) begin
          state_d     = ST_IDLE;
          fill_done_d = 1'b0;
        end else if (mem_ready) begin
          line_we       = 1'b1;
          mem_req_d     = 1'b0;
          fill_done_d   = 1'b1;
          refill_done_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          cpu_ready = 1'b1;
          word_we   = hit_q;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      hit_q         <= 1'b0;
      fill_done_q   <= 1'b0;
      refill_done_q <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      hit_q         <= hit_d;
      fill_done_q   <= fill_done_d;
      refill_done_q <= refill_done_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end
endmodule

// File: tb/tb_d_cache.sv
// Self-checking bench for d_cache: transaction-level cache model plus a memory with fixed latency.
module tb_d_cache;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] hit_count, miss_count;

  d_cache #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(8)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory; untouched words read as addr ^ 0xA5A5.
  logic [15:0] mem [logic [15:0]];
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 16'hA5A5);
  endfunction

  int req_cnt = 0;
  always @(posedge clk) begin
    #1;
    mem_ready = 1'b0;
    if (mem_req) begin
      req_cnt++;
      if (req_cnt == L) begin
        mem_ready = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else for (int i = 0; i < 4; i++) mem_rdata[i*16 +: 16] = mem_word(mem_addr + 16'(i));
      end
    end else begin
      req_cnt = 0;
    end
  end

  // Cache model: contents per line and statistics.
  bit          m_valid [8];
  logic [10:0] m_tag   [8];
  logic [15:0] m_line  [8][4];
  int          m_hits = 0, m_misses = 0;

  // Current transaction: kind 0 none, 1 read hit, 2 read miss, 3 write; t = cycles since request.
  int          kind = 0, t = -1, exp_ready_t = 0;
  logic [15:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
  int          obs_ready_t = -1;
  logic [15:0] obs_rdata = '0, obs_mem_addr = '0;
  logic        obs_mem_we = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  always @(negedge clk) begin
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
    if (kind == 0) begin
      chk("idle_ready", 32'(cpu_ready), 1);
      chk("idle_mem_req", 32'(mem_req), 0);
    end else if (kind == 1) begin
      chk("hit_ready", 32'(cpu_ready), 1);
      chk("hit_rdata", 32'(cpu_rdata), 32'(exp_rdata));
      chk("hit_mem_req", 32'(mem_req), 0);
    end else begin
      chk("ready_timing", 32'(cpu_ready), 32'(t == exp_ready_t));
      chk("mem_req_timing", 32'(mem_req), 32'(t >= 1 && t <= L));
      if (t >= 1 && t <= L) begin
        chk("mem_we", 32'(mem_we), 32'(kind == 3));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (kind == 3) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      if (kind == 2 && t == exp_ready_t) chk("miss_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    end
    if (kind != 0) begin
      if (cpu_ready && obs_ready_t < 0) begin
        obs_ready_t = t;
        obs_rdata   = cpu_rdata;
      end
      if (mem_req) begin
        obs_mem_addr = mem_addr;
        obs_mem_we   = mem_we;
      end
    end
  end

  // Issue one access (called at posedge+1); abort_at > 0 pulls reset in that cycle of the access.
  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d, input int abort_at);
    int          idx, off;
    logic [10:0] tg;
    bit          hit, stop;
    idx = int'(a[4:2]);
    off = int'(a[1:0]);
    tg  = a[15:5];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_addr    = wr ? a : {a[15:2], 2'b00};
    exp_wdata   = d;
    exp_rdata   = hit ? m_line[idx][off] : mem_word(a);
    exp_ready_t = wr ? L : (hit ? 0 : L + 2);
    obs_ready_t = -1;
    obs_rdata   = '0;
    obs_mem_addr = '0;
    obs_mem_we  = 1'b0;
    kind = wr ? 3 : (hit ? 1 : 2);
    t = 0;
    cpu_write = wr;
    cpu_read  = !wr;
    cpu_addr  = a;
    cpu_wdata = d;
    stop = 1'b0;
    for (int c = 1; c <= exp_ready_t + 1 && !stop; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        if (hit) m_hits++;
        else     m_misses++;
      end
      if (c == abort_at) begin
        t = c;
        #2;
        reset_n = 1'b0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        kind = 0;
        t = -1;
        model_reset();
        #1;
        chk("abort_mem_req", 32'(mem_req), 0);
        chk("abort_hit_count", 32'(hit_count), 0);
        chk("abort_miss_count", 32'(miss_count), 0);
        stop = 1'b1;
      end else if (c == exp_ready_t + 1) begin
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        kind = 0;
        t = -1;
        if (!wr && !hit) begin
          m_valid[idx] = 1'b1;
          m_tag[idx] = tg;
          for (int i = 0; i < 4; i++) m_line[idx][i] = mem_word({a[15:2], 2'b00} + 16'(i));
        end
        if (wr && hit) m_line[idx][off] = d;
      end else begin
        t = c;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    mem[16'h0010] = 16'h000A;
    mem[16'h0011] = 16'h000B;
    mem[16'h0012] = 16'h000C;
    mem[16'h0013] = 16'h000D;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 32'(cpu_ready), 1);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
    reset_n = 1'b1;
    idle_cycle();

    // Cold read miss fills line 0x0010.
    access(1'b0, 16'h0013, 16'h0000, -1);
    chk("s1_ready_t", 32'(obs_ready_t), 6);
    chk("s1_rdata", 32'(obs_rdata), 'h000D);
    chk("s1_mem_addr", 32'(obs_mem_addr), 'h0010);
    chk("s1_miss", 32'(miss_count), 1);
    chk("s1_hit", 32'(hit_count), 0);
    idle_cycle();

    access(1'b0, 16'h0011, 16'h0000, -1);
    chk("s2_ready_t", 32'(obs_ready_t), 0);
    chk("s2_rdata", 32'(obs_rdata), 'h000B);
    chk("s2_hit", 32'(hit_count), 1);
    idle_cycle();

    // Write hit updates memory and the cached word.
    access(1'b1, 16'h0012, 16'h55AA, -1);
    chk("s3_ready_t", 32'(obs_ready_t), 4);
    chk("s3_mem_we", 32'(obs_mem_we), 1);
    chk("s3_mem_addr", 32'(obs_mem_addr), 'h0012);
    chk("s3_mem", 32'(mem_word(16'h0012)), 'h55AA);
    chk("s3_hit", 32'(hit_count), 2);
    idle_cycle();
    access(1'b0, 16'h0012, 16'h0000, -1);
    chk("s3_rd_ready_t", 32'(obs_ready_t), 0);
    chk("s3_rd_rdata", 32'(obs_rdata), 'h55AA);
    chk("s3_rd_hit", 32'(hit_count), 3);
    idle_cycle();

    // Write miss goes to memory only; the following read still misses.
    access(1'b1, 16'h0100, 16'h1234, -1);
    chk("s4_ready_t", 32'(obs_ready_t), 4);
    chk("s4_mem", 32'(mem_word(16'h0100)), 'h1234);
    chk("s4_miss", 32'(miss_count), 2);
    idle_cycle();
    access(1'b0, 16'h0100, 16'h0000, -1);
    chk("s4_rd_ready_t", 32'(obs_ready_t), 6);
    chk("s4_rd_rdata", 32'(obs_rdata), 'h1234);
    chk("s4_rd_mem_addr", 32'(obs_mem_addr), 'h0100);
    chk("s4_rd_miss", 32'(miss_count), 3);
    idle_cycle();

    // Reset in the 2nd FILL cycle aborts the refill and clears everything.
    access(1'b0, 16'h0033, 16'h0000, 2);
    repeat (2) idle_cycle();
    reset_n = 1'b1;
    idle_cycle();
    access(1'b0, 16'h0013, 16'h0000, -1);
    chk("s6_ready_t", 32'(obs_ready_t), 6);
    chk("s6_rdata", 32'(obs_rdata), 'h000D);
    chk("s6_miss", 32'(miss_count), 1);
    chk("s6_hit", 32'(hit_count), 0);
    idle_cycle();

    // Conflict on index 4: tags 0 and 1 evict each other.
    access(1'b0, 16'h0033, 16'h0000, -1);
    chk("s5_ready_t", 32'(obs_ready_t), 6);
    chk("s5_rdata", 32'(obs_rdata), 'hA596);
    chk("s5_miss", 32'(miss_count), 2);
    idle_cycle();
    access(1'b0, 16'h0013, 16'h0000, -1);
    chk("s5_re_ready_t", 32'(obs_ready_t), 6);
    chk("s5_re_rdata", 32'(obs_rdata), 'h000D);
    chk("s5_re_miss", 32'(miss_count), 3);
    chk("s5_re_hit", 32'(hit_count), 0);
    repeat (2) idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
